// File: rtl/sif_mc_bridge_if.sv
// Host (XA) and write-access (WA) bus bundle for sif_mc_bridge.
// master = host plus consumers driving the bridge, slave = the bridge itself.
interface sif_mc_bridge_if #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int NCH = 2
);
  logic [AW-1:0]     xa_addr;
  logic [DW-1:0]     xa_data_wr;
  logic              xa_wr_s;
  logic              xa_rd_s;
  logic [DW-1:0]     xa_data_rd;
  logic              xa_rd_vld;
  logic [NCH*AW-1:0] wa_addr;
  logic [NCH*DW-1:0] wa_data_wr;
  logic [NCH-1:0]    wa_wr_s;
  logic [NCH-1:0]    wa_rdy;
  logic [NCH-1:0]    xa_full;

  modport master (
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_rdy,
    input  xa_data_rd, xa_rd_vld, wa_addr, wa_data_wr, wa_wr_s, xa_full
  );

  modport slave (
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_rdy,
    output xa_data_rd, xa_rd_vld, wa_addr, wa_data_wr, wa_wr_s, xa_full
  );
endinterface

// File: rtl/sif_mc_bridge.sv
// Multi-channel SIF write bridge: routes host writes into per-channel FWFT FIFOs.
// Optional macro SIF_DROP_CNT_EN adds an 8-bit saturating drop counter per channel.
module sif_mc_bridge #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sif_mc_bridge_if.slave  bus
);
  localparam int CHW  = $clog2(NCH);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int EW   = AW + DW;

  logic [EW-1:0]   mem [NCH][FIFO_DEPTH];
  logic [CNTW-1:0] cnt [NCH];
  logic [CNTW-1:0] cnt_nxt [NCH];
  logic [PW-1:0]   wr_ptr [NCH];
  logic [PW-1:0]   rd_ptr [NCH];
  logic [PW-1:0]   rd_ptr_nxt [NCH];
  logic [NCH-1:0]  ovf;
  logic [NCH-1:0]  hit_rd, push, drop, pop, load_new, head_upd;
  logic [CHW-1:0]  ch;
  logic [DW-1:0]   status;
  logic [EW-1:0]   wr_entry;

`ifdef SIF_DROP_CNT_EN
  logic [7:0]      drop_cnt [NCH];
`endif

  assign ch       = bus.xa_addr[AW-1 -: CHW];
  assign wr_entry = {bus.xa_addr, bus.xa_data_wr};

  always_comb begin
    hit_rd      = '0;
    push        = '0;
    drop        = '0;
    pop         = '0;
    load_new    = '0;
    head_upd    = '0;
    bus.wa_wr_s = '0;
    for (int c = 0; c < NCH; c++) begin
      hit_rd[c]      = bus.xa_rd_s && (ch == CHW'(c));
      push[c]        = bus.xa_wr_s && (ch == CHW'(c)) && (cnt[c] != CNTW'(FIFO_DEPTH));
      drop[c]        = bus.xa_wr_s && (ch == CHW'(c)) && (cnt[c] == CNTW'(FIFO_DEPTH));
      pop[c]         = (cnt[c] != '0) && bus.wa_rdy[c];
      cnt_nxt[c]     = cnt[c] + CNTW'(push[c]) - CNTW'(pop[c]);
      rd_ptr_nxt[c]  = rd_ptr[c] + PW'(pop[c]);
      // Pushed entry becomes the head only if nothing else remains after the pop.
      load_new[c]    = push[c] && ((cnt[c] == '0) || ((cnt[c] == CNTW'(1)) && pop[c]));
      head_upd[c]    = cnt_nxt[c] != '0;
      bus.wa_wr_s[c] = cnt[c] != '0;
    end
  end

  always_comb begin
    status            = '0;
    status[DW-1]      = ovf[ch];
    status[CNTW-1:0]  = cnt[ch];
`ifdef SIF_DROP_CNT_EN
    status[15:8]      = drop_cnt[ch];
`endif
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]    <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      ovf            <= '0;
      bus.xa_full    <= '0;
      bus.wa_addr    <= '0;
      bus.wa_data_wr <= '0;
      bus.xa_data_rd <= '0;
      bus.xa_rd_vld  <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]         <= cnt_nxt[c];
        rd_ptr[c]      <= rd_ptr_nxt[c];
        bus.xa_full[c] <= cnt_nxt[c] == CNTW'(FIFO_DEPTH);
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        // Set wins over read-clear.
        if (drop[c])        ovf[c] <= 1'b1;
        else if (hit_rd[c]) ovf[c] <= 1'b0;
        // Lanes hold their last value once the channel runs empty.
        if (load_new[c]) begin
          bus.wa_addr[c*AW +: AW]    <= bus.xa_addr;
          bus.wa_data_wr[c*DW +: DW] <= bus.xa_data_wr;
        end else if (head_upd[c]) begin
          bus.wa_addr[c*AW +: AW]    <= mem[c][rd_ptr_nxt[c]][EW-1 -: AW];
          bus.wa_data_wr[c*DW +: DW] <= mem[c][rd_ptr_nxt[c]][DW-1:0];
        end
      end
      bus.xa_rd_vld <= bus.xa_rd_s;
      if (bus.xa_rd_s) bus.xa_data_rd <= status;
    end
  end

`ifdef SIF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) drop_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hit_rd[c])                          drop_cnt[c] <= drop[c] ? 8'd1 : 8'd0;
        else if (drop[c] && drop_cnt[c] != 8'hFF) drop_cnt[c] <= drop_cnt[c] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sif_mc_bridge.sv
// Directed self-checking bench for sif_mc_bridge (NCH=2, FIFO_DEPTH=4, AW=DW=16).
module tb_sif_mc_bridge;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  sif_mc_bridge_if #(.AW(16), .DW(16), .NCH(2)) bus ();

  sif_mc_bridge #(.AW(16), .DW(16), .NCH(2), .FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SIF_DROP_CNT_EN
  localparam logic [15:0] OVF2_RD   = 16'h8204;
  localparam logic [15:0] OVF_SET_RD = 16'h8104;
  localparam logic [15:0] FP_RD     = 16'h8103;
`else
  localparam logic [15:0] OVF2_RD   = 16'h8004;
  localparam logic [15:0] OVF_SET_RD = 16'h8004;
  localparam logic [15:0] FP_RD     = 16'h8003;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are stable for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.xa_addr = a; bus.xa_data_wr = d; bus.xa_wr_s = 1'b1;
    tick();
    bus.xa_wr_s = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.xa_addr = a; bus.xa_rd_s = 1'b1;
    tick();
    bus.xa_rd_s = 1'b0;
    chk({tag, "_vld"}, 32'(bus.xa_rd_vld), 32'd1);
    chk(tag, 32'(bus.xa_data_rd), 32'(exp));
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.xa_addr = '0; bus.xa_data_wr = '0; bus.xa_wr_s = 1'b0;
    bus.xa_rd_s = 1'b0; bus.wa_rdy = 2'b00;
    #1;
    chk("rst_wr_s", 32'(bus.wa_wr_s), 32'd0);
    chk("rst_full", 32'(bus.xa_full), 32'd0);
    chk("rst_rd_vld", 32'(bus.xa_rd_vld), 32'd0);
    chk("rst_data_rd", 32'(bus.xa_data_rd), 32'd0);
    chk("rst_wa_addr", bus.wa_addr, 32'd0);
    chk("rst_wa_data", bus.wa_data_wr, 32'd0);
    #6 rst_n = 1'b1;
    tick();

    // Reset mid-drain
    wr(16'h0001, 16'h0101); wr(16'h0002, 16'h0102); wr(16'h0003, 16'h0103);
    chk("mid_pre_vld", 32'(bus.wa_wr_s), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_s", 32'(bus.wa_wr_s), 32'd0);
    chk("mid_rst_full", 32'(bus.xa_full), 32'd0);
    chk("mid_rst_lane", bus.wa_data_wr, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    rd("mid_rd_ch0", 16'h0000, 16'h0000);
    tick();
    chk("rd_vld_pulse", 32'(bus.xa_rd_vld), 32'd0);
    chk("rd_data_hold", 32'(bus.xa_data_rd), 32'd0);

    // Routing
    bus.wa_rdy = 2'b11;
    wr(16'h0010, 16'hAAAA);
    chk("rt_vld0", 32'(bus.wa_wr_s), 32'h1);
    chk("rt_addr0", 32'(bus.wa_addr[15:0]), 32'h0010);
    chk("rt_data0", 32'(bus.wa_data_wr[15:0]), 32'hAAAA);
    wr(16'h8020, 16'h5555);
    chk("rt_vld1", 32'(bus.wa_wr_s), 32'h2);
    chk("rt_addr1", 32'(bus.wa_addr[31:16]), 32'h8020);
    chk("rt_data1", 32'(bus.wa_data_wr[31:16]), 32'h5555);
    chk("rt_hold0", 32'(bus.wa_data_wr[15:0]), 32'hAAAA);
    tick();
    chk("rt_empty", 32'(bus.wa_wr_s), 32'h0);

    // Backpressure and order
    bus.wa_rdy = 2'b00;
    wr(16'h0000, 16'd1); wr(16'h0000, 16'd2); wr(16'h0000, 16'd3);
    chk("bp_full3", 32'(bus.xa_full), 32'h0);
    wr(16'h0000, 16'd4);
    chk("bp_full4", 32'(bus.xa_full), 32'h1);
    tick();
    chk("bp_stall_head", 32'(bus.wa_data_wr[15:0]), 32'd1);
    bus.wa_rdy = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("bp_drain%0d_vld", i), 32'(bus.wa_wr_s[0]), 32'd1);
      chk($sformatf("bp_drain%0d", i), 32'(bus.wa_data_wr[15:0]), 32'(i));
      tick();
      if (i == 1) chk("bp_full_clr", 32'(bus.xa_full), 32'h0);
    end
    chk("bp_done", 32'(bus.wa_wr_s), 32'h0);

    // Overflow, clear-on-read and set-wins
    bus.wa_rdy = 2'b00;
    for (int i = 0; i < 6; i++) wr(16'h0000, 16'(16'h0011 + i));
    chk("ovf_head", 32'(bus.wa_data_wr[15:0]), 32'h0011);
    rd("ovf_rd1", 16'h0000, OVF2_RD);
    bus.xa_addr = 16'h0000; bus.xa_data_wr = 16'h00EE;
    bus.xa_wr_s = 1'b1; bus.xa_rd_s = 1'b1;
    tick();
    bus.xa_wr_s = 1'b0; bus.xa_rd_s = 1'b0;
    chk("ovf_rd_clr", 32'(bus.xa_data_rd), 32'h0004);
    rd("ovf_setwin", 16'h0000, OVF_SET_RD);
    rd("ovf_rd3", 16'h0000, 16'h0004);
    bus.wa_rdy = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), 32'(bus.wa_data_wr[15:0]), 32'(16'h0011 + i));
      tick();
    end
    chk("ovf_done", 32'(bus.wa_wr_s), 32'h0);

    // Simultaneous push, read and pop on ch1
    bus.wa_rdy = 2'b00;
    wr(16'h8000, 16'h0B01); wr(16'h8001, 16'h0B02);
    bus.xa_addr = 16'h8002; bus.xa_data_wr = 16'h0B03;
    bus.xa_wr_s = 1'b1; bus.xa_rd_s = 1'b1; bus.wa_rdy = 2'b10;
    tick();
    bus.xa_wr_s = 1'b0; bus.xa_rd_s = 1'b0; bus.wa_rdy = 2'b00;
    chk("sim_rd", 32'(bus.xa_data_rd), 32'h0002);
    chk("sim_head", 32'(bus.wa_data_wr[31:16]), 32'h0B02);
    rd("sim_cnt", 16'h8000, 16'h0002);
    bus.wa_rdy = 2'b10;
    chk("sim_o1", 32'(bus.wa_data_wr[31:16]), 32'h0B02);
    tick();
    chk("sim_o2", 32'(bus.wa_data_wr[31:16]), 32'h0B03);
    chk("sim_o2_addr", 32'(bus.wa_addr[31:16]), 32'h8002);
    tick();
    chk("sim_done", 32'(bus.wa_wr_s), 32'h0);

    // Full and pop in the same cycle
    bus.wa_rdy = 2'b00;
    for (int i = 0; i < 4; i++) wr(16'h0000, 16'(16'h0021 + i));
    bus.xa_addr = 16'h0000; bus.xa_data_wr = 16'h0025;
    bus.xa_wr_s = 1'b1; bus.wa_rdy = 2'b01;
    tick();
    bus.xa_wr_s = 1'b0; bus.wa_rdy = 2'b00;
    chk("fp_full", 32'(bus.xa_full), 32'h0);
    rd("fp_rd", 16'h0000, FP_RD);
    bus.wa_rdy = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fp_drain%0d", i), 32'(bus.wa_data_wr[15:0]), 32'(16'h0022 + i));
      tick();
    end
    chk("fp_done", 32'(bus.wa_wr_s), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sif_mc_bridge.md
Name: sif_mc_bridge

Overview:
- Multi-channel successor to the single-channel SIF write bridge: accepts strobed XA-side writes and routes each into one of NCH WA-side write channels.
- Channel is decoded from the top address bits; each channel buffers writes in a FIFO and drains them through a valid/ready handshake.
- XA-side reads return per-channel status (fill level, sticky overflow) with fixed 1-cycle latency.
- Sits between the SIF host port and the downstream write-access consumers.

Parameters:
- AW, 16, address width (xa_addr and each wa_addr lane).
- DW, 16, data width; must be >= 16.
- NCH, 2, channel count; power of 2, >= 2. CHW = $clog2(NCH).
- FIFO_DEPTH, 4, entries per channel; power of 2, 2..128. CNTW = $clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- xa_addr  in  AW  host address; xa_addr[AW-1 -: CHW] selects the channel.
- xa_data_wr  in  DW  host write data.
- xa_wr_s  in  1  host write strobe, one write per high cycle.
- xa_rd_s  in  1  host status-read strobe.
- xa_data_rd  out  DW  status read data.
- xa_rd_vld  out  1  one-cycle pulse; xa_data_rd is valid.
- wa_addr  out  NCH*AW  per-channel head address; lane c = [c*AW +: AW].
- wa_data_wr  out  NCH*DW  per-channel head data; lane c = [c*DW +: DW].
- wa_wr_s  out  NCH  per-channel valid.
- wa_rdy  in  NCH  per-channel consumer ready.
- xa_full  out  NCH  per-channel FIFO full, registered.

Behaviour:
- Reset, asynchronous and effective immediately, including mid-operation:
  - All FIFOs emptied; counts and sticky overflow cleared.
  - xa_data_rd=0, xa_rd_vld=0, wa_wr_s=0, wa_addr=0, wa_data_wr=0, xa_full=0.
  - Entries in flight are discarded.
- Write path:
  - On a posedge with xa_wr_s=1, {xa_addr, xa_data_wr} is pushed into FIFO ch = xa_addr[AW-1 -: CHW].
  - The full AW address is stored and forwarded unmodified.
- Full: fullness is judged on count at the start of the cycle. If count==FIFO_DEPTH, the push is dropped and ovf[ch] is set, even if a pop happens in the same cycle.
- FIFO output is first-word-fall-through:
  - wa_wr_s[c]=1 whenever count[c]>0.
  - wa_addr and wa_data_wr lanes show the head entry.
  - When the FIFO is empty, the lanes hold their last value; wa_wr_s=0.
- Handshake:
  - Transfer occurs on a posedge with wa_wr_s[c]=1 and wa_rdy[c]=1; the head is popped and the next entry presents the following cycle.
  - Back-to-back transfers run one per cycle.
  - The consumer may toggle wa_rdy freely; head data stays stable while wa_wr_s=1 and wa_rdy=0.
- Latency: a write to an empty channel at edge k gives wa_wr_s high after edge k. Throughput is 1 per cycle per channel.
- Simultaneous push and pop on a non-full channel: count unchanged, ordering preserved.
- Status read: on a posedge with xa_rd_s=1, ch = xa_addr[AW-1 -: CHW]. After that edge:
  - xa_rd_vld=1 for 1 cycle.
  - xa_data_rd = {ovf[ch] at bit DW-1, zeros, count[ch] in [CNTW-1:0]}, with drop count per Optional Feature.
  - Reported values are the pre-edge state.
  - xa_data_rd holds between reads.
- The read clears ovf[ch]. If a drop on the same channel occurs in the same cycle, set wins and ovf stays 1.
- Simultaneous xa_wr_s and xa_rd_s: both are served. A read of the same channel reports the pre-write count.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- xa_full[c] = (count[c]==FIFO_DEPTH), registered with count.

Optional Feature:
- Macro: SIF_DROP_CNT_EN.
- Defined:
  - Each channel has an 8-bit saturating drop counter: it increments per dropped write and stops at 255.
  - It is reported in xa_data_rd[15:8] on a status read and cleared by that read.
  - A drop in the same cycle as the clearing read leaves the counter at 1.
  - Reset clears it to 0.
- Not defined: no counter logic; xa_data_rd[15:8] read 0.

Test Plan:
- Reset mid-drain: fill ch0 with 3 entries, drive rst_n=0 asynchronously between edges -> wa_wr_s=0 and xa_full=0 immediately; after release, status read of ch0 returns 0x0000.
- Routing: write (addr 0x0010, data 0xAAAA) then (addr 0x8020, data 0x5555), wa_rdy=2'b11 -> ch0 presents 0x0010/0xAAAA and ch1 presents 0x8020/0x5555, each with wa_wr_s high 1 cycle after its write edge.
- Backpressure and order: wa_rdy[0]=0, write data 1,2,3,4 to ch0 -> xa_full[0]=1; raise wa_rdy[0] -> 1,2,3,4 drain on 4 consecutive cycles, then wa_wr_s[0]=0.
- Overflow: ch0 full, 2 more writes -> both dropped, read ch0 returns 0x8004 (0x8204 with SIF_DROP_CNT_EN); second read returns 0x0004.
- Simultaneous events: count=2 on ch1, same cycle xa_wr_s to ch1, xa_rd_s of ch1, and ch1 pop -> read returns 0x0002, count stays 2.
- Full-and-pop: ch0 full with wa_rdy[0]=1 and a write in the same cycle -> write dropped, ovf[0]=1, count=3.
